// File: rtl/capture_pkg.sv
// Shared constants for the LVDS capture sequencer: state encoding, buffer
// geometry defaults and the number of ping-pong banks.
package capture_pkg;

  localparam int DEF_BUFFER_SIZE = 4096;
  localparam int DEF_ADDR_W      = 12;
  localparam int NUM_BANKS       = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_TRIG    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

endpackage

// File: rtl/capture_bank_tracker.sv
// Ping-pong bank bookkeeping: full flags, write pointer, release handling and
// the sticky overrun flag raised while ARM waits on a full bank.
module capture_bank_tracker
  import capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_commit,
  input  logic                 i_arm,
  input  logic [NUM_BANKS-1:0] i_release,
  input  logic                 i_ovr_clr,
  output logic [NUM_BANKS-1:0] o_bank_full,
  output logic                 o_ptr,
  output logic                 o_cur_full,
  output logic                 o_overrun
);

  logic [NUM_BANKS-1:0] r_bank_full;
  logic                 r_ptr;
  logic                 r_overrun;
  logic [NUM_BANKS-1:0] w_set;
  logic                 w_cur_full;

  assign w_set      = {i_commit & r_ptr, i_commit & ~r_ptr};
  assign w_cur_full = r_bank_full[r_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
      r_ptr       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // A commit setting a bank beats a release of that same bank.
      r_bank_full <= w_set | (r_bank_full & ~i_release);
      if (i_commit)
        r_ptr <= ~r_ptr;
      if (i_arm && w_cur_full)
        r_overrun <= 1'b1;
      else if (i_ovr_clr)
        r_overrun <= 1'b0;
    end
  end

  assign o_bank_full = r_bank_full;
  assign o_ptr       = r_ptr;
  assign o_cur_full  = w_cur_full;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/capture_seq.sv
// LVDS capture sequencer: turns start/stop/cont into buffer write strobes.
// Define CAPTURE_SEQ_TRIG_EN to add a pattern-trigger state before capture.
module capture_seq
  import capture_pkg::*;
#(
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   LVDS_CLK,
  input  logic                   LVDS_RESETN,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   stop,
  input  logic [NUM_BANKS-1:0]   bank_release,
  input  logic                   ovr_clr,
`ifdef CAPTURE_SEQ_TRIG_EN
  input  logic [3:0]             lvds_in,
  input  logic [3:0]             trig_pattern,
`endif
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   wr_bank,
  output logic [NUM_BANKS-1:0]   bank_full,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic [2:0]             r_state;
  logic [2:0]             w_next_state;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_cont;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   w_commit;
  logic                   w_arm;
  logic                   w_last;
  logic                   w_ptr;
  logic                   w_cur_full;
  logic                   w_overrun;
  logic [NUM_BANKS-1:0]   w_bank_full;

  assign w_commit = (r_state == ST_COMMIT);
  assign w_arm    = (r_state == ST_ARM);
  assign w_last   = (r_addr == ADDR_W'(BUFFER_SIZE - 1));

`ifdef CAPTURE_SEQ_TRIG_EN
  logic w_trig_hit;
  // The matching sample is itself written as address 0.
  assign w_trig_hit = (r_state == ST_TRIG) && (lvds_in == trig_pattern) && !stop;
`endif

  capture_bank_tracker u_tracker (
    .clk         (LVDS_CLK),
    .rst_n       (LVDS_RESETN),
    .i_commit    (w_commit),
    .i_arm       (w_arm),
    .i_release   (bank_release),
    .i_ovr_clr   (ovr_clr),
    .o_bank_full (w_bank_full),
    .o_ptr       (w_ptr),
    .o_cur_full  (w_cur_full),
    .o_overrun   (w_overrun)
  );

  // NOTE: the next-state default is assigned first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_ARM;
      ST_ARM: begin
        if (stop)
          w_next_state = ST_IDLE;
        else if (!w_cur_full)
`ifdef CAPTURE_SEQ_TRIG_EN
          w_next_state = ST_TRIG;
`else
          w_next_state = ST_CAPTURE;
`endif
      end
`ifdef CAPTURE_SEQ_TRIG_EN
      ST_TRIG: begin
        if (stop)
          w_next_state = ST_IDLE;
        else if (w_trig_hit)
          w_next_state = ST_CAPTURE;
      end
`endif
      ST_CAPTURE: if (w_last) w_next_state = ST_COMMIT;
      ST_COMMIT:  w_next_state = (r_cont && !stop) ? ST_ARM : ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge LVDS_CLK or negedge LVDS_RESETN) begin
    if (!LVDS_RESETN) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cont      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      // cont is sampled only when a start is accepted; stop only ever clears it.
      if (r_state == ST_IDLE && start)
        r_cont <= cont;
      else if (stop)
        r_cont <= 1'b0;
      if (r_state == ST_CAPTURE)
        r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
`ifdef CAPTURE_SEQ_TRIG_EN
      else if (w_trig_hit)
        r_addr <= ADDR_W'(1);
`endif
      if (w_commit)
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

`ifdef CAPTURE_SEQ_TRIG_EN
  assign wr_en = (r_state == ST_CAPTURE) || w_trig_hit;
`else
  assign wr_en = (r_state == ST_CAPTURE);
`endif
  assign wr_addr   = r_addr;
  assign wr_bank   = w_ptr;
  assign bank_full = w_bank_full;
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_commit;
  assign overrun   = w_overrun;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_capture_seq.sv
// Scoreboard bench for capture_seq: expected writes and commits are queued as
// stimulus is driven and matched against the DUT on the falling clock edge.
module tb_capture_seq;

  localparam int BS = 4096;
  localparam int AW = 12;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          stop = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [1:0]    man_rel = 2'b00;
  logic [1:0]    auto_rel = 2'b00;
  logic [1:0]    bank_release;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic [1:0]    bank_full;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [FW-1:0] frame_cnt;
`ifdef CAPTURE_SEQ_TRIG_EN
  logic [3:0]    lvds_in = 4'h0;
  logic [3:0]    trig_pattern = 4'h0;
`endif

  assign bank_release = man_rel | auto_rel;

  always #5 clk = ~clk;

  capture_seq dut (
    .LVDS_CLK     (clk),
    .LVDS_RESETN  (rst_n),
    .start        (start),
    .cont         (cont),
    .stop         (stop),
    .bank_release (bank_release),
    .ovr_clr      (ovr_clr),
`ifdef CAPTURE_SEQ_TRIG_EN
    .lvds_in      (lvds_in),
    .trig_pattern (trig_pattern),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_bank      (wr_bank),
    .bank_full    (bank_full),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  typedef struct {
    logic bank;
    int   addr;
    int   gap;   // expected cycles since previous write, 0 = unchecked
  } wr_t;

  wr_t  wr_q[$];
  logic done_q[$];
  wr_t  mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_wr = 0;
  int   done_cnt = 0;
  bit   auto_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check("wr_extra", 32'(wr_en), 0);
        end else begin
          mon_e = wr_q.pop_front();
          check("wr_bank", 32'(wr_bank), 32'(mon_e.bank));
          check("wr_addr", 32'(wr_addr), mon_e.addr);
          if (mon_e.gap != 0) check("wr_gap", cyc - last_wr, mon_e.gap);
        end
        last_wr <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (done_q.size() == 0) check("done_extra", 32'(done), 0);
        else                    check("done_bank", 32'(wr_bank), 32'(done_q.pop_front()));
      end
    end
  end

  // Software model: releases each committed bank 50 cycles after its done.
  initial begin
    logic b;
    forever begin
      @(negedge clk);
      if (rst_n && done && auto_en) begin
        b = wr_bank;
        repeat (50) @(posedge clk);
        #1 auto_rel[b] = 1'b1;
        @(posedge clk);
        #1 auto_rel = 2'b00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_burst(input logic bank, input int first_gap);
    for (int i = 0; i < BS; i++) wr_q.push_back('{bank, i, (i == 0) ? first_gap : 1});
    done_q.push_back(bank);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
    tick();
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 1);
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    tick();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_bank", 32'(wr_bank), 0);
    check("rst_bank_full", 32'(bank_full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Single shot, with a start (and cont=1) presented while busy
    cont = 1'b0;
    push_burst(1'b0, 0);
    pulse_start();
    repeat (1000) tick();
    cont = 1'b1;
    pulse_start();
    cont = 1'b0;
    wait_idle(6000);
    repeat (20) tick();
    check("ss_bank_full", 32'(bank_full), 1);
    check("ss_frame_cnt", 32'(frame_cnt), 1);
    check("ss_busy", 32'(busy), 0);
    check("ss_overrun", 32'(overrun), 0);
    check("ss_q_empty", wr_q.size(), 0);
    man_rel = 2'b10;
    tick();
    man_rel = 2'b00;
    check("rel_not_full", 32'(bank_full), 1);
    man_rel = 2'b01;
    tick();
    man_rel = 2'b00;
    check("rel_bank0", 32'(bank_full), 0);

    // Continuous with prompt release, stop mid fourth burst
    do_reset();
    auto_en = 1'b1;
    cont = 1'b1;
    push_burst(1'b0, 0);
    push_burst(1'b1, 3);
    push_burst(1'b0, 3);
    push_burst(1'b1, 3);
    base = done_cnt;
    pulse_start();
    wait_done(base + 3, 3 * 4200);
    tick();
    repeat (500) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cont = 1'b0;
    wait_idle(5000);
    auto_en = 1'b0;
    repeat (60) tick();
    check("cont_frame_cnt", 32'(frame_cnt), 4);
    check("cont_overrun", 32'(overrun), 0);
    check("cont_bank_full", 32'(bank_full), 0);
    check("cont_q_empty", wr_q.size(), 0);

    // Overrun: no releases, bank 1 released on its own commit cycle
    do_reset();
    cont = 1'b1;
    push_burst(1'b0, 0);
    push_burst(1'b1, 3);
    base = done_cnt;
    pulse_start();
    wait_done(base + 1, 4300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 5000);
    check("commit1_seen", 32'(done), 1);
    man_rel = 2'b10;
    @(posedge clk);
    #1 man_rel = 2'b00;
    check("rel_vs_commit", 32'(bank_full), 3);
    repeat (3) tick();
    check("ovr_set", 32'(overrun), 1);
    check("ovr_busy", 32'(busy), 1);
    check("ovr_no_wr", 32'(wr_en), 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr_on_stall", 32'(overrun), 1);
    push_burst(1'b0, 0);
    man_rel = 2'b01;
    tick();
    man_rel = 2'b00;
    check("resume_flag_clear", 32'(bank_full), 2);
    check("resume_wait", 32'(wr_en), 0);
    tick();
    check("resume_wr_en", 32'(wr_en), 1);
    check("resume_addr", 32'(wr_addr), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cont = 1'b0;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
    wait_idle(5000);
    check("ovr_frame_cnt", 32'(frame_cnt), 3);
    check("ovr_bank_full", 32'(bank_full), 3);
    check("ovr_q_empty", wr_q.size(), 0);

    // Reset in mid-capture at wr_addr 1000 (pointer is on bank 1 here)
    man_rel = 2'b11;
    tick();
    man_rel = 2'b00;
    for (int i = 0; i <= 1000; i++) wr_q.push_back('{1'b1, i, (i == 0) ? 0 : 1});
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_en && wr_addr == AW'(1000)) && n < 2000);
    check("mid_addr_reached", 32'(wr_addr), 1000);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_wr_en", 32'(wr_en), 0);
    check("mrst_wr_addr", 32'(wr_addr), 0);
    check("mrst_wr_bank", 32'(wr_bank), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_frame_cnt", 32'(frame_cnt), 0);
    check("mrst_bank_full", 32'(bank_full), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_overrun", 32'(overrun), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_q_empty", wr_q.size(), 0);
    push_burst(1'b0, 0);
    pulse_start();
    wait_idle(5000);
    check("post_rst_frame_cnt", 32'(frame_cnt), 1);
    check("post_rst_bank_full", 32'(bank_full), 1);

`ifdef CAPTURE_SEQ_TRIG_EN
    // Trigger on 4'hA presented 37 cycles after start
    do_reset();
    trig_pattern = 4'hA;
    lvds_in = 4'h0;
    push_burst(1'b0, 0);
    pulse_start();
    repeat (36) tick();
    @(negedge clk);
    check("trig_wait", 32'(wr_en), 0);
    tick();
    lvds_in = 4'hA;
    @(negedge clk);
    check("trig_wr_en", 32'(wr_en), 1);
    check("trig_addr", 32'(wr_addr), 0);
    tick();
    lvds_in = 4'h0;
    wait_idle(5000);
    check("trig_frame_cnt", 32'(frame_cnt), 1);
`endif

    check("final_wr_q", wr_q.size(), 0);
    check("final_done_q", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
